// File: rtl/console_pkg.sv
// Shared definitions for the text console writer: control bytes, FSM states,
// default screen geometry and small cell-formatting helpers.
package console_pkg;

    localparam int DEFAULT_COLS = 100;
    localparam int DEFAULT_ROWS = 30;

    localparam logic [7:0] CH_BS    = 8'h08;
    localparam logic [7:0] CH_LF    = 8'h0A;
    localparam logic [7:0] CH_FF    = 8'h0C;
    localparam logic [7:0] CH_CR    = 8'h0D;
    localparam logic [7:0] CH_ESC   = 8'h1B;
    localparam logic [7:0] CH_SPACE = 8'h20;
    localparam logic [7:0] CH_TILDE = 8'h7E;

    localparam logic [6:0] GLYPH_SPACE = 7'h20;

    typedef enum logic [1:0] {
        ST_IDLE       = 2'd0,
        ST_CLR_LINE   = 2'd1,
        ST_CLR_SCREEN = 2'd2
    } console_state_e;

    // True for bytes that produce a visible glyph write.
    function automatic logic is_printable(input logic [7:0] ch);
        return (ch >= CH_SPACE) && (ch <= CH_TILDE);
    endfunction

    // Text-RAM cell layout: attribute in the high byte, 7-bit glyph below.
    function automatic logic [15:0] make_cell(input logic [7:0] attr, input logic [6:0] glyph);
        return {attr, 1'b0, glyph};
    endfunction

endpackage

// File: rtl/console_cursor.sv
// Cursor tracker: column, row and the row-base address (row*COLS) kept as a
// running sum so no multiplier is needed. Commands are mutually exclusive;
// home has highest priority.
module console_cursor
    import console_pkg::*;
#(
    parameter int COLS = DEFAULT_COLS,
    parameter int ROWS = DEFAULT_ROWS
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cmd_advance,
    input  logic        cmd_newline,
    input  logic        cmd_cr,
    input  logic        cmd_backspace,
    input  logic        cmd_home,
    output logic [7:0]  col,
    output logic [7:0]  row,
    output logic [11:0] row_base
);

    localparam logic [7:0]  LAST_COL  = 8'(COLS - 1);
    localparam logic [7:0]  LAST_ROW  = 8'(ROWS - 1);
    localparam logic [11:0] COLS_STEP = 12'(COLS);

    logic [7:0]  col_r, col_next_s;
    logic [7:0]  row_r, row_next_s;
    logic [11:0] base_r, base_next_s;
    logic        line_adv_s;

    // Next cursor position from the current command.
    always_comb begin
        col_next_s  = col_r;
        row_next_s  = row_r;
        base_next_s = base_r;
        line_adv_s  = 1'b0;
        if (cmd_home) begin
            col_next_s  = 8'd0;
            row_next_s  = 8'd0;
            base_next_s = 12'd0;
        end else if (cmd_newline) begin
            line_adv_s = 1'b1;
        end else if (cmd_advance) begin
            if (col_r == LAST_COL) begin
                line_adv_s = 1'b1;
            end else begin
                col_next_s = col_r + 8'd1;
            end
        end else if (cmd_cr) begin
            col_next_s = 8'd0;
        end else if (cmd_backspace) begin
            if (col_r != 8'd0) begin
                col_next_s = col_r - 8'd1;
            end else begin
                col_next_s = col_r;
            end
        end else begin
            col_next_s = col_r;
        end

        if (line_adv_s) begin
            col_next_s = 8'd0;
            if (row_r == LAST_ROW) begin
                row_next_s  = 8'd0;
                base_next_s = 12'd0;
            end else begin
                row_next_s  = row_r + 8'd1;
                base_next_s = base_r + COLS_STEP;
            end
        end else begin
            row_next_s = row_next_s;
        end
    end

    // Cursor registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            col_r  <= 8'd0;
            row_r  <= 8'd0;
            base_r <= 12'd0;
        end else begin
            col_r  <= col_next_s;
            row_r  <= row_next_s;
            base_r <= base_next_s;
        end
    end

    assign col      = col_r;
    assign row      = row_r;
    assign row_base = base_r;

endmodule

// File: rtl/text_console_writer.sv
// Byte-stream to text-RAM writer. Printable bytes are written at the cursor;
// LF/line wrap clear the new line, FF clears the whole screen. RAM strobe,
// address and data are registered and reflect the previous cycle's decision.
// Optional feature macro: CONSOLE_ATTR_ESC_EN (ESC loads the next byte as attr).
module text_console_writer
    import console_pkg::*;
#(
    parameter int         COLS         = DEFAULT_COLS,
    parameter int         ROWS         = DEFAULT_ROWS,
    parameter logic [7:0] DEFAULT_ATTR = 8'h0F
) (
    input  logic        ram_clk,
    input  logic        ram_reset,
    input  logic        in_valid,
    input  logic [7:0]  in_char,
    output logic        in_ready,
    output logic        ram_ce,
    output logic [11:0] ram_addr,
    output logic [15:0] ram_data,
    output logic [7:0]  cursor_col,
    output logic [7:0]  cursor_row,
    output logic        busy
);

    localparam logic [7:0]  LAST_COL     = 8'(COLS - 1);
    localparam logic [11:0] LAST_COL_CNT = 12'(COLS - 1);
    localparam logic [11:0] LAST_CELL    = 12'(COLS * ROWS - 1);

    console_state_e state_r, state_next_s;
    logic [11:0] clr_cnt_r, clr_cnt_next_s;
    logic        ram_ce_r, wr_ce_s;
    logic [11:0] ram_addr_r, wr_addr_s;
    logic [15:0] ram_data_r, wr_data_s;
    logic        in_ready_s, accept_s, plain_accept_s;
    logic [7:0]  attr_s;
    logic [7:0]  col_s, row_s;
    logic [11:0] row_base_s;
    logic        cmd_advance_s, cmd_newline_s, cmd_cr_s, cmd_bs_s, cmd_home_s;

    assign in_ready_s = (state_r == ST_IDLE) && !ram_reset;
    assign accept_s   = in_valid && in_ready_s;

`ifdef CONSOLE_ATTR_ESC_EN
    logic [7:0] attr_r;
    logic       esc_armed_r;

    assign attr_s         = attr_r;
    assign plain_accept_s = accept_s && !esc_armed_r && (in_char != CH_ESC);

    // ESC arms the flag; the byte after it is taken verbatim as the new attr.
    always_ff @(posedge ram_clk) begin
        if (ram_reset) begin
            attr_r      <= DEFAULT_ATTR;
            esc_armed_r <= 1'b0;
        end else if (accept_s && esc_armed_r) begin
            attr_r      <= in_char;
            esc_armed_r <= 1'b0;
        end else if (accept_s && (in_char == CH_ESC)) begin
            esc_armed_r <= 1'b1;
        end else begin
            esc_armed_r <= esc_armed_r;
        end
    end
`else
    assign attr_s         = DEFAULT_ATTR;
    assign plain_accept_s = accept_s;
`endif

    console_cursor #(
        .COLS (COLS),
        .ROWS (ROWS)
    ) u_cursor (
        .clk           (ram_clk),
        .reset         (ram_reset),
        .cmd_advance   (cmd_advance_s),
        .cmd_newline   (cmd_newline_s),
        .cmd_cr        (cmd_cr_s),
        .cmd_backspace (cmd_bs_s),
        .cmd_home      (cmd_home_s),
        .col           (col_s),
        .row           (row_s),
        .row_base      (row_base_s)
    );

    // Byte decode, clear sequencing, cursor commands and next RAM write.
    always_comb begin
        state_next_s   = state_r;
        clr_cnt_next_s = clr_cnt_r;
        wr_ce_s        = 1'b0;
        wr_addr_s      = ram_addr_r;
        wr_data_s      = ram_data_r;
        cmd_advance_s  = 1'b0;
        cmd_newline_s  = 1'b0;
        cmd_cr_s       = 1'b0;
        cmd_bs_s       = 1'b0;
        cmd_home_s     = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (plain_accept_s) begin
                    if (is_printable(in_char)) begin
                        wr_ce_s       = 1'b1;
                        wr_addr_s     = row_base_s + {4'd0, col_s};
                        wr_data_s     = make_cell(attr_s, in_char[6:0]);
                        cmd_advance_s = 1'b1;
                        if (col_s == LAST_COL) begin
                            state_next_s   = ST_CLR_LINE;
                            clr_cnt_next_s = 12'd0;
                        end else begin
                            state_next_s = ST_IDLE;
                        end
                    end else begin
                        case (in_char)
                            CH_LF: begin
                                cmd_newline_s  = 1'b1;
                                state_next_s   = ST_CLR_LINE;
                                clr_cnt_next_s = 12'd0;
                            end
                            CH_CR: cmd_cr_s = 1'b1;
                            CH_BS: cmd_bs_s = 1'b1;
                            CH_FF: begin
                                state_next_s   = ST_CLR_SCREEN;
                                clr_cnt_next_s = 12'd0;
                            end
                            default: state_next_s = ST_IDLE;
                        endcase
                    end
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_CLR_LINE: begin
                wr_ce_s   = 1'b1;
                wr_addr_s = row_base_s + clr_cnt_r;
                wr_data_s = make_cell(attr_s, GLYPH_SPACE);
                if (clr_cnt_r == LAST_COL_CNT) begin
                    state_next_s   = ST_IDLE;
                    clr_cnt_next_s = 12'd0;
                end else begin
                    clr_cnt_next_s = clr_cnt_r + 12'd1;
                end
            end
            ST_CLR_SCREEN: begin
                wr_ce_s   = 1'b1;
                wr_addr_s = clr_cnt_r;
                wr_data_s = make_cell(attr_s, GLYPH_SPACE);
                if (clr_cnt_r == LAST_CELL) begin
                    state_next_s   = ST_IDLE;
                    clr_cnt_next_s = 12'd0;
                    cmd_home_s     = 1'b1;
                end else begin
                    clr_cnt_next_s = clr_cnt_r + 12'd1;
                end
            end
            default: begin
                state_next_s   = ST_IDLE;
                clr_cnt_next_s = 12'd0;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge ram_clk) begin
        if (ram_reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Clear counter and registered RAM write port.
    always_ff @(posedge ram_clk) begin
        if (ram_reset) begin
            clr_cnt_r  <= 12'd0;
            ram_ce_r   <= 1'b0;
            ram_addr_r <= 12'd0;
            ram_data_r <= 16'd0;
        end else begin
            clr_cnt_r  <= clr_cnt_next_s;
            ram_ce_r   <= wr_ce_s;
            ram_addr_r <= wr_addr_s;
            ram_data_r <= wr_data_s;
        end
    end

    assign in_ready   = in_ready_s;
    assign ram_ce     = ram_ce_r;
    assign ram_addr   = ram_addr_r;
    assign ram_data   = ram_data_r;
    assign cursor_col = col_s;
    assign cursor_row = row_s;
    assign busy       = (state_r != ST_IDLE);

endmodule

// File: tb/tb_text_console_writer.sv
// Directed self-checking bench for text_console_writer (default geometry).
module tb_text_console_writer;

    logic        ram_clk;
    logic        ram_reset;
    logic        in_valid;
    logic [7:0]  in_char;
    logic        in_ready;
    logic        ram_ce;
    logic [11:0] ram_addr;
    logic [15:0] ram_data;
    logic [7:0]  cursor_col;
    logic [7:0]  cursor_row;
    logic        busy;

    int n_vec = 0;
    int n_err = 0;

    text_console_writer dut (
        .ram_clk    (ram_clk),
        .ram_reset  (ram_reset),
        .in_valid   (in_valid),
        .in_char    (in_char),
        .in_ready   (in_ready),
        .ram_ce     (ram_ce),
        .ram_addr   (ram_addr),
        .ram_data   (ram_data),
        .cursor_col (cursor_col),
        .cursor_row (cursor_row),
        .busy       (busy)
    );

    initial ram_clk = 1'b0;
    always #5 ram_clk = ~ram_clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge ram_clk);
        #1;
    endtask

    task automatic send(input logic [7:0] c);
        in_char  = c;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic wait_idle(input int bound);
        int k;
        k = 0;
        while (busy && k < bound) begin
            tick();
            k++;
        end
        chk("wait_idle", {31'd0, busy}, 32'd0);
    endtask

    initial begin
        logic [7:0] c;
        int busy_cnt;
        int bad_cnt;
        int ce_cnt;

        ram_reset = 1'b1;
        in_valid  = 1'b0;
        in_char   = 8'h00;

        // Reset state
        tick();
        tick();
        chk("in_ready_in_reset", {31'd0, in_ready}, 32'd0);
        ram_reset = 1'b0;
        #1;
        chk("rst_ce_addr_data", {3'd0, ram_ce, ram_addr, ram_data}, 32'd0);
        chk("rst_cursor", {16'd0, cursor_row, cursor_col}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);

        // Single printable 'A'
        send(8'h41);
        chk("A_write", {3'd0, ram_ce, ram_addr, ram_data}, {3'd0, 1'b1, 12'd0, 16'h0F41});
        chk("A_cursor", {16'd0, cursor_row, cursor_col}, {16'd0, 8'd0, 8'd1});
        tick();
        chk("A_ce_drops", {31'd0, ram_ce}, 32'd0);

        // CR, BS at col 0, printable, BS
        send(8'h0D);
        chk("CR_no_write", {31'd0, ram_ce}, 32'd0);
        chk("CR_col", {24'd0, cursor_col}, 32'd0);
        send(8'h08);
        chk("BS_at0", {23'd0, ram_ce, cursor_col}, 32'd0);
        send(8'h42);
        chk("B_write", {3'd0, ram_ce, ram_addr, ram_data}, {3'd0, 1'b1, 12'd0, 16'h0F42});
        send(8'h08);
        chk("BS_dec", {23'd0, ram_ce, cursor_col}, 32'd0);

        // Ignored bytes
        send(8'h7F);
        chk("DEL_ignored", {23'd0, ram_ce, cursor_col}, 32'd0);
        send(8'h01);
        chk("SOH_ignored", {23'd0, ram_ce, cursor_col}, 32'd0);
        send(8'hC1);
        chk("HIGH_ignored", {23'd0, ram_ce, cursor_col}, 32'd0);
`ifndef CONSOLE_ATTR_ESC_EN
        send(8'h1B);
        chk("ESC_ignored", {23'd0, ram_ce, cursor_col}, 32'd0);
`endif

        // 100 printables fill row 0 then line wrap clears row 1
        in_valid = 1'b1;
        for (int i = 0; i < 100; i++) begin
            c = 8'(8'h30 + (i % 40));
            in_char = c;
            tick();
            if (i == 99) in_valid = 1'b0;
            chk("row0_write", {3'd0, ram_ce, ram_addr, ram_data},
                {3'd0, 1'b1, 12'(i), 8'h0F, 1'b0, c[6:0]});
        end
        in_valid = 1'b0;
        chk("wrap_busy_inready", {30'd0, busy, in_ready}, {30'd0, 1'b1, 1'b0});
        busy_cnt = 1;
        for (int j = 0; j < 100; j++) begin
            tick();
            if (busy) busy_cnt++;
            chk("row1_clear", {3'd0, ram_ce, ram_addr, ram_data},
                {3'd0, 1'b1, 12'(100 + j), 16'h0F20});
        end
        chk("wrap_busy_cycles", 32'(busy_cnt), 32'd100);
        chk("wrap_cursor", {16'd0, cursor_row, cursor_col}, {16'd0, 8'd1, 8'd0});
        chk("wrap_in_ready", {31'd0, in_ready}, 32'd1);
        tick();
        chk("wrap_ce_drops", {31'd0, ram_ce}, 32'd0);

        // LFs down to row 29
        for (int k = 0; k < 28; k++) begin
            send(8'h0A);
            wait_idle(200);
        end
        chk("row29_cursor", {16'd0, cursor_row, cursor_col}, {16'd0, 8'd29, 8'd0});
        send(8'h58);
        chk("X_row29", {3'd0, ram_ce, ram_addr, ram_data}, {3'd0, 1'b1, 12'd2900, 16'h0F58});

        // LF from last row wraps to row 0 and clears it
        send(8'h0A);
        chk("LF_first_cycle", {29'd0, ram_ce, busy, in_ready}, {29'd0, 1'b0, 1'b1, 1'b0});
        chk("LF_wrap_cursor", {16'd0, cursor_row, cursor_col}, 32'd0);
        for (int j = 0; j < 100; j++) begin
            tick();
            chk("row0_clear", {3'd0, ram_ce, ram_addr, ram_data},
                {3'd0, 1'b1, 12'(j), 16'h0F20});
        end
        chk("LF_done", {30'd0, busy, in_ready}, {30'd0, 1'b0, 1'b1});

        // Form feed clears the whole screen
        send(8'h51);
        chk("Q_write", {3'd0, ram_ce, ram_addr, ram_data}, {3'd0, 1'b1, 12'd0, 16'h0F51});
        send(8'h0C);
        chk("FF_first_cycle", {29'd0, ram_ce, busy, in_ready}, {29'd0, 1'b0, 1'b1, 1'b0});
        bad_cnt = 0;
        for (int j = 0; j < 3000; j++) begin
            tick();
            if (j < 2999 && in_ready !== 1'b0) bad_cnt++;
            chk("screen_clear", {3'd0, ram_ce, ram_addr, ram_data},
                {3'd0, 1'b1, 12'(j), 16'h0F20});
        end
        chk("FF_in_ready_low", 32'(bad_cnt), 32'd0);
        chk("FF_done", {14'd0, busy, in_ready, cursor_row, cursor_col}, {14'd0, 1'b0, 1'b1, 16'd0});
        tick();
        chk("FF_ce_drops", {31'd0, ram_ce}, 32'd0);

        // Reset in the middle of a screen clear
        send(8'h4D);
        send(8'h0C);
        for (int j = 0; j < 38; j++) tick();
        chk("abort_cell37", {19'd0, ram_ce, ram_addr}, {19'd0, 1'b1, 12'd37});
        ram_reset = 1'b1;
        tick();
        chk("abort_ce_addr", {19'd0, ram_ce, ram_addr}, 32'd0);
        chk("abort_busy_rdy", {30'd0, busy, in_ready}, 32'd0);
        chk("abort_cursor", {16'd0, cursor_row, cursor_col}, 32'd0);
        ram_reset = 1'b0;
        #1;
        chk("abort_rdy_release", {31'd0, in_ready}, 32'd1);
        ce_cnt = 0;
        for (int j = 0; j < 5; j++) begin
            tick();
            if (ram_ce) ce_cnt++;
        end
        chk("abort_no_writes", 32'(ce_cnt), 32'd0);
        chk("abort_idle", {30'd0, busy, in_ready}, {30'd0, 1'b0, 1'b1});

`ifdef CONSOLE_ATTR_ESC_EN
        // ESC sequence loads a new attribute
        send(8'h1B);
        chk("ESC_no_write", {23'd0, ram_ce, cursor_col}, 32'd0);
        send(8'h4E);
        chk("ATTR_no_write", {23'd0, ram_ce, cursor_col}, 32'd0);
        send(8'h5A);
        chk("Z_with_attr", {3'd0, ram_ce, ram_addr, ram_data}, {3'd0, 1'b1, 12'd0, 16'h4E5A});
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
